sram_spi_arbiter: RTL and testbench

- Shares the single serial SPI SRAM between two CPU requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Arbitrates round-robin and issues one SPI transaction per request: READ 0x03 or WRITE 0x02, then the address, then the data bytes.
- Returns read data and a one-cycle ack.
- Sits between the CPU core and the sclk/sram_ce/si/so pads.

---
 rtl/sram_arb_pkg.sv | 43 ++++
 rtl/sram_spi_arbiter_if.sv | 32 +++
 rtl/spi_shift_engine.sv | 80 ++++++++
 rtl/sram_spi_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_spi_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants, types and helpers for the SPI SRAM arbiter.
// Data is little-endian in memory but shifted MSB-first, so bytes are swapped on both paths.
package sram_arb_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    // Size code 3 is treated as a word.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // The first received byte sits highest in the shift window; undo that and zero-extend.
    function automatic logic [31:0] unpack_rx(input logic [31:0] rx, input logic [1:0] size);
        case (size)
            SZ_BYTE: unpack_rx = {24'h0, rx[7:0]};
            SZ_HALF: unpack_rx = {16'h0, rx[7:0], rx[15:8]};
            default: unpack_rx = bswap32(rx);
        endcase
    endfunction

endpackage

// File: rtl/sram_spi_arbiter_if.sv
// CPU-side request/ack bus of the SPI SRAM arbiter: port 0 is fetch (read-only), port 1 is data.
interface sram_spi_arbiter_if #(
    parameter int unsigned ADDR_BITS = 24
);
    logic                 req0;
    logic [ADDR_BITS-1:0] addr0;
    logic [1:0]           size0;
    logic [31:0]          rdata0;
    logic                 ack0;

    logic                 req1;
    logic                 we1;
    logic [ADDR_BITS-1:0] addr1;
    logic [1:0]           size1;
    logic [31:0]          wdata1;
    logic [31:0]          rdata1;
    logic                 ack1;

    modport master (
        output req0, addr0, size0,
        input  rdata0, ack0,
        output req1, we1, addr1, size1, wdata1,
        input  rdata1, ack1
    );

    modport slave (
        input  req0, addr0, size0,
        output rdata0, ack0,
        input  req1, we1, addr1, size1, wdata1,
        output rdata1, ack1
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: divides clk into sclk, shifts a left-aligned tx word MSB-first
// and collects the last 32 received bits.
module spi_shift_engine #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned TX_W    = 64,
    parameter int unsigned CNT_W   = $clog2(TX_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] nbits,
    input  logic [TX_W-1:0]  tx_word,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rx_word,
    output logic             sclk,
    output logic             si,
    input  logic             so
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(CLK_DIV - 1);

    logic             active_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] left_q;
    logic [TX_W-1:0]  tx_q;
    logic [31:0]      rx_q;
    logic             sclk_q;
    logic             si_q;
    logic             rise;
    logic             fall;

    assign rise    = active_q && (div_q == RISE_AT);
    assign fall    = active_q && (div_q == FALL_AT);
    // Combinational so the caller can react on the same edge that ends the last bit.
    assign done    = fall && (left_q == '0);
    assign busy    = active_q;
    assign rx_word = rx_q;
    assign sclk    = sclk_q;
    assign si      = si_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            left_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            si_q     <= 1'b0;
        end else if (!active_q) begin
            if (start) begin
                active_q <= 1'b1;
                div_q    <= '0;
                left_q   <= nbits - 1'b1;
                si_q     <= tx_word[TX_W-1];
                tx_q     <= tx_word << 1;
            end
        end else begin
            div_q <= fall ? '0 : div_q + 1'b1;
            if (rise) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[30:0], so};
            end
            if (fall) begin
                sclk_q <= 1'b0;
                if (left_q == '0) begin
                    active_q <= 1'b0;
                    si_q     <= 1'b0;
                end else begin
                    si_q   <= tx_q[TX_W-1];
                    tx_q   <= tx_q << 1;
                    left_q <= left_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_spi_arbiter.sv
// Round-robin arbiter sharing one serial SPI SRAM between instruction fetch (port 0)
// and data load/store (port 1); one READ/WRITE transaction per request.
module sram_spi_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned CE_GAP    = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_spi_arbiter_if.slave  bus,
    output logic               busy,
    output logic               sclk,
    output logic               sram_ce,
    output logic               si,
    input  logic               so
);
    localparam int unsigned TX_W  = 8 + ADDR_BITS + 32;
    localparam int unsigned CNT_W = $clog2(TX_W + 1);
    localparam int unsigned GAP_W = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_XFER = XFER;
    localparam logic [1:0] S_DONE = DONE;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q;
    logic             port_q;
    logic [1:0]       size_q;
    logic             ce_q;
    logic             ack0_q, ack1_q;
    logic [31:0]      rdata0_q, rdata1_q;
    logic [GAP_W-1:0] gap_q;

    logic                 grant_valid;
    logic                 grant_port;
    logic [ADDR_BITS-1:0] g_addr;
    logic [1:0]           g_size;
    logic                 g_we;
    logic [TX_W-1:0]      tx_word;
    logic [CNT_W-1:0]     nbits;
    logic                 eng_start, eng_busy, eng_done;
    logic [31:0]          rx_word;

    always_comb begin
        grant_valid = (state_q == S_IDLE) && (bus.req0 || bus.req1);
        // Under contention the port that did not win last time goes first.
        if (bus.req0 && bus.req1) grant_port = ~last_grant_q;
        else                      grant_port = bus.req1;
        g_addr  = grant_port ? bus.addr1 : bus.addr0;
        g_size  = grant_port ? bus.size1 : bus.size0;
        g_we    = grant_port & bus.we1;
        tx_word = {g_we ? OP_WRITE : OP_READ, g_addr, g_we ? bswap32(bus.wdata1) : 32'h0};
        nbits   = CNT_W'(8 + ADDR_BITS) + CNT_W'({nbytes(g_size), 3'b000});
    end

    assign eng_start = grant_valid && !eng_busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (eng_start) state_d = S_XFER;
            S_XFER:  if (eng_done) state_d = S_DONE;
            S_DONE:  state_d = S_GAP;
            default: if (gap_q == GAP_W'(CE_GAP - 1)) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            size_q       <= 2'd0;
            ce_q         <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            gap_q        <= '0;
        end else begin
            state_q <= state_d;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            gap_q   <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
            if (eng_start) begin
                port_q       <= grant_port;
                size_q       <= g_size;
                last_grant_q <= grant_port;
                ce_q         <= 1'b0;
            end
            if (state_q == S_XFER && eng_done) begin
                ce_q <= 1'b1;
                if (port_q) begin
                    ack1_q   <= 1'b1;
                    rdata1_q <= unpack_rx(rx_word, size_q);
                end else begin
                    ack0_q   <= 1'b1;
                    rdata0_q <= unpack_rx(rx_word, size_q);
                end
            end
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .TX_W    (TX_W),
        .CNT_W   (CNT_W)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (eng_start),
        .nbits   (nbits),
        .tx_word (tx_word),
        .busy    (eng_busy),
        .done    (eng_done),
        .rx_word (rx_word),
        .sclk    (sclk),
        .si      (si),
        .so      (so)
    );

    assign busy       = (state_q != S_IDLE);
    assign sram_ce    = ce_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_sram_spi_arbiter.sv
// Directed bench for sram_spi_arbiter with a behavioural 24-bit-address SPI SRAM model.
module tb_sram_spi_arbiter;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned ADDR_BITS = 24;
    localparam int unsigned CE_GAP    = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy, sclk, sram_ce, si, so;
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_spi_arbiter_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    sram_spi_arbiter #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_BITS (ADDR_BITS),
        .CE_GAP    (CE_GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .sclk    (sclk),
        .sram_ce (sram_ce),
        .si      (si),
        .so      (so)
    );

    always #5 clk = ~clk;

    // SRAM model: mode 0, samples si on sclk rise, drives so after sclk fall.
    logic [7:0]  mem [0:255];
    int unsigned bitn = 0;
    int unsigned k;
    logic [31:0] hdr = '0;
    logic [7:0]  wbyte = '0;
    logic [7:0]  last_op = '0, first_op = '0;
    logic [23:0] last_addr = '0, first_addr = '0;
    bit          seen_first = 0;

    always @(posedge sclk or posedge sram_ce) begin
        if (sram_ce) begin
            bitn = 0;
        end else begin
            if (bitn < 32) begin
                hdr = {hdr[30:0], si};
                if (bitn == 31) begin
                    last_op   = hdr[31:24];
                    last_addr = hdr[23:0];
                    if (!seen_first) begin
                        first_op   = hdr[31:24];
                        first_addr = hdr[23:0];
                        seen_first = 1;
                    end
                end
            end else if (last_op == 8'h02) begin
                wbyte = {wbyte[6:0], si};
                if (((bitn - 32) % 8) == 7)
                    mem[8'(last_addr + 24'((bitn - 32) / 8))] = wbyte;
            end
            bitn++;
        end
    end

    always @(negedge sclk or posedge sram_ce) begin
        if (sram_ce) begin
            so = 1'b0;
        end else if (last_op == 8'h03 && bitn >= 32) begin
            k  = bitn - 32;
            so = mem[8'(last_addr + 24'(k / 8))][7 - (k % 8)];
        end
    end

    // Bus monitors sampled away from the active edge.
    int sclk_viol = 0;
    int overlap   = 0;
    int ack1_count = 0;
    int ce_run    = 0;
    int ack_seq[$];
    int ce_runs[$];

    always @(negedge clk) begin
        if (sram_ce === 1'b1 && sclk !== 1'b0) sclk_viol++;
        if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) overlap++;
        if (bus.ack0 === 1'b1) ack_seq.push_back(0);
        if (bus.ack1 === 1'b1) begin
            ack_seq.push_back(1);
            ack1_count++;
        end
        if (sram_ce === 1'b1) begin
            ce_run++;
        end else begin
            if (ce_run > 0) ce_runs.push_back(ce_run);
            ce_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request with the DUT idle; lat is cycles from grant to ack (-1 on timeout).
    task automatic xfer(input bit port, input bit we, input logic [23:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int ce_c);
        @(posedge clk); #1;
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.size1 = size; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.addr0 = addr; bus.size0 = size;
        end
        lat  = -1;
        ce_c = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            if (ce_c < 0 && sram_ce === 1'b0) ce_c = c;
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = c;
                break;
            end
        end
        rdata = port ? bus.rdata1 : bus.rdata0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (CE_GAP + 2) @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (sram_ce !== 1'b1 || sclk !== 1'b0 || si !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pads: ce=%b sclk=%b si=%b required 1,0,0", sram_ce, sclk, si);
        end
        n_checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_acks: ack0=%b ack1=%b required 0,0", bus.ack0, bus.ack1);
        end
        n_checks++;
        if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: %h %h required 0", bus.rdata0, bus.rdata1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || sram_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b ce=%b required 0,1", busy, sram_ce);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat, ce_c;
        xfer(1'b1, 1'b1, 24'h000010, 2'd2, 32'hDEADBEEF, rd, lat, ce_c);
        n_checks++;
        if (lat != 1 + 64 * CLK_DIV) begin
            n_fail++;
            $display("FAIL write_word_latency: got %0d required %0d", lat, 1 + 64 * CLK_DIV);
        end
        n_checks++;
        if (ce_c != 1) begin
            n_fail++;
            $display("FAIL ce_fall_cycle: got %0d required 1", ce_c);
        end
        n_checks++;
        if (first_op !== 8'h02 || first_addr !== 24'h000010) begin
            n_fail++;
            $display("FAIL first_header: op=%h addr=%h required 02 000010", first_op, first_addr);
        end
        n_checks++;
        if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_mem: got %h %h %h %h required EF BE AD DE",
                     mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
        end
        xfer(1'b1, 1'b0, 24'h000010, 2'd2, 32'h0, rd, lat, ce_c);
        n_checks++;
        if (rd !== 32'hDEADBEEF || lat != 1 + 64 * CLK_DIV) begin
            n_fail++;
            $display("FAIL read_word: got %h lat %0d required DEADBEEF lat %0d",
                     rd, lat, 1 + 64 * CLK_DIV);
        end
        n_checks++;
        if (last_op !== 8'h03 || last_addr !== 24'h000010) begin
            n_fail++;
            $display("FAIL read_header: op=%h addr=%h required 03 000010", last_op, last_addr);
        end
        n_checks++;
        if (bus.rdata1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rdata1_hold: got %h required DEADBEEF", bus.rdata1);
        end
    endtask

    task automatic test_byte_read();
        logic [31:0] rd;
        int lat, ce_c;
        xfer(1'b0, 1'b0, 24'h000011, 2'd0, 32'h0, rd, lat, ce_c);
        n_checks++;
        if (rd !== 32'h000000BE) begin
            n_fail++;
            $display("FAIL byte_read: got %h required 000000BE", rd);
        end
        n_checks++;
        if (lat != 1 + 40 * CLK_DIV) begin
            n_fail++;
            $display("FAIL byte_latency: got %0d required %0d", lat, 1 + 40 * CLK_DIV);
        end
    endtask

    task automatic test_half_write();
        logic [31:0] rd;
        int lat, ce_c;
        xfer(1'b1, 1'b1, 24'h000007, 2'd1, 32'h0000A5A5, rd, lat, ce_c);
        n_checks++;
        if (lat != 1 + 48 * CLK_DIV) begin
            n_fail++;
            $display("FAIL half_latency: got %0d required %0d", lat, 1 + 48 * CLK_DIV);
        end
        xfer(1'b1, 1'b0, 24'h000006, 2'd2, 32'h0, rd, lat, ce_c);
        n_checks++;
        if (rd !== 32'h00A5A500) begin
            n_fail++;
            $display("FAIL half_readback: got %h required 00A5A500", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, ce_c, acks_before;
        acks_before = ack1_count;
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 24'h000020;
        bus.size1 = 2'd2; bus.wdata1 = 32'h11223344;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (sram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_active: ce=%b required 0", sram_ce);
        end
        reset = 1'b0;
        bus.req1 = 1'b0;
        #1;
        n_checks++;
        if (sram_ce !== 1'b1 || sclk !== 1'b0 || si !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pads: ce=%b sclk=%b si=%b busy=%b required 1,0,0,0",
                     sram_ce, sclk, si, busy);
        end
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_rdata1: got %h required 0", bus.rdata1);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        n_checks++;
        if (ack1_count != acks_before) begin
            n_fail++;
            $display("FAIL mid_no_ack: got %0d acks required %0d", ack1_count, acks_before);
        end
        n_checks++;
        if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_write_lost: got %h%h%h%h required 00000000",
                     mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]);
        end
        xfer(1'b1, 1'b0, 24'h000010, 2'd2, 32'h0, rd, lat, ce_c);
        n_checks++;
        if (rd !== 32'hDEADBEEF || lat != 1 + 64 * CLK_DIV) begin
            n_fail++;
            $display("FAIL post_reset_read: got %h lat %0d required DEADBEEF lat %0d",
                     rd, lat, 1 + 64 * CLK_DIV);
        end
    endtask

    task automatic test_contention();
        int n;
        logic [31:0] r0, r1;
        n  = 0;
        r0 = '0;
        r1 = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        ack_seq.delete();
        ce_runs.delete();
        bus.req0 = 1'b1; bus.addr0 = 24'h000010; bus.size0 = 2'd0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 24'h000010; bus.size1 = 2'd2;
        for (int c = 0; c < 3000 && n < 4; c++) begin
            @(posedge clk); #1;
            if (bus.ack0 === 1'b1) begin n++; r0 = bus.rdata0; end
            if (bus.ack1 === 1'b1) begin n++; r1 = bus.rdata1; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (CE_GAP + 4) @(posedge clk);
        #1;
        n_checks++;
        if (ack_seq.size() != 4 || ack_seq[0] != 0 || ack_seq[1] != 1 ||
            ack_seq[2] != 0 || ack_seq[3] != 1) begin
            n_fail++;
            $display("FAIL grant_order: got %p required '{0,1,0,1}", ack_seq);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL ack_overlap: got %0d overlapping cycles required 0", overlap);
        end
        n_checks++;
        if (ce_runs.size() != 4 || ce_runs[1] != CE_GAP + 2 || ce_runs[2] != CE_GAP + 2 ||
            ce_runs[3] != CE_GAP + 2) begin
            n_fail++;
            $display("FAIL ce_gap: got %p required three inner gaps of %0d", ce_runs, CE_GAP + 2);
        end
        n_checks++;
        if (r0 !== 32'h000000EF || r1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL contention_data: got %h %h required 000000EF DEADBEEF", r0, r1);
        end
        n_checks++;
        if (sclk_viol != 0) begin
            n_fail++;
            $display("FAIL sclk_idle: got %0d cycles with sclk high while ce high required 0",
                     sclk_viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.size0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.size1 = '0; bus.wdata1 = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        test_reset();
        test_write_read();
        test_byte_read();
        test_half_write();
        test_reset_mid();
        test_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
